// File: rtl/me_search_sched.sv
// Frame-level scheduler for the full-search motion-estimation datapath.
// Walks the current blocks in raster order. Each block gets FILL_CYC SAD-pipeline fill cycles
// and then a 32-cycle search window. Each block's best vector and SAD are captured into a
// single-entry valid/ready result register.
module me_search_sched #(
    parameter int unsigned BLK_COLS = 8,
    parameter int unsigned BLK_ROWS = 6,
    parameter int unsigned FILL_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        sad_en_o,
    output logic        cmp_pause_o,
    output logic [7:0]  cur_x_o,
    output logic [7:0]  cur_y_o,
    output logic [3:0]  cand_col_o,
    input  logic        cmp_finish_i,
    input  logic [3:0]  cmp_mv_x_i,
    input  logic [3:0]  cmp_mv_y_i,
    input  logic [13:0] cmp_sad_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [7:0]  res_x_o,
    output logic [7:0]  res_y_o,
    output logic [3:0]  res_mv_x_o,
    output logic [3:0]  res_mv_y_o,
    output logic [13:0] res_sad_o,
    output logic        err_sync_o
);

    localparam logic [7:0] LastX    = 8'(BLK_COLS - 1);
    localparam logic [7:0] LastY    = 8'(BLK_ROWS - 1);
    localparam logic [3:0] LastFill = 4'(FILL_CYC - 1);

    typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

    state_e      state_q, state_d;
    logic [3:0]  fill_q, fill_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  cur_x_q, cur_x_d;
    logic [7:0]  cur_y_q, cur_y_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic        res_valid_q;
    logic [7:0]  res_x_q, res_y_q;
    logic [3:0]  res_mv_x_q, res_mv_y_q;
    logic [13:0] res_sad_q;

    logic slot_free, last_blk, win_end;

    // Result slot is free now or is being emptied by the consumer this cycle.
    assign slot_free = !res_valid_q || res_ready_i;
    assign last_blk  = (cur_x_q == LastX) && (cur_y_q == LastY);
    assign win_end   = (state_q == StRun) && (cnt_q == 5'd31);

    // State and control counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            fill_q  <= 4'd0;
            cnt_q   <= 5'd0;
            cur_x_q <= 8'd0;
            cur_y_q <= 8'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and per-state enables for the SAD array and comparator.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        err_d       = err_q;
        done_d      = 1'b0;
        sad_en_o    = 1'b0;
        cmp_pause_o = 1'b1;
        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse belongs to the finished frame.
                if (start_i && !done_q) begin
                    state_d = StFill;
                    fill_d  = 4'd0;
                    cnt_d   = 5'd0;
                    cur_x_d = 8'd0;
                    cur_y_d = 8'd0;
                    err_d   = 1'b0;
                end
            end
            StFill: begin
                sad_en_o = 1'b1;
                if (fill_q == LastFill) begin
                    // Hold here until the next capture cannot overwrite an unread result.
                    if (slot_free) begin
                        state_d = StRun;
                        cnt_d   = 5'd0;
                    end
                end else begin
                    fill_d = fill_q + 4'd1;
                end
            end
            StRun: begin
                sad_en_o    = 1'b1;
                cmp_pause_o = 1'b0;
                cnt_d       = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    if (!cmp_finish_i) begin
                        err_d = 1'b1;
                    end
                    if (last_blk) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StFill;
                        fill_d  = 4'd0;
                        if (cur_x_q == LastX) begin
                            cur_x_d = 8'd0;
                            cur_y_d = cur_y_q + 8'd1;
                        end else begin
                            cur_x_d = cur_x_q + 8'd1;
                        end
                    end
                end
            end
            StDrain: begin
                if (slot_free) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result register: capture at window end, release on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q <= 1'b0;
            res_x_q     <= 8'd0;
            res_y_q     <= 8'd0;
            res_mv_x_q  <= 4'd0;
            res_mv_y_q  <= 4'd0;
            res_sad_q   <= 14'd0;
        end else if (win_end) begin
            res_valid_q <= 1'b1;
            res_x_q     <= cur_x_q;
            res_y_q     <= cur_y_q;
            if (cmp_finish_i) begin
                res_mv_x_q <= cmp_mv_x_i;
                res_mv_y_q <= cmp_mv_y_i;
                res_sad_q  <= cmp_sad_i;
            end else begin
                // Comparator lost sync: report a worst-case SAD with a zero vector.
                res_mv_x_q <= 4'd0;
                res_mv_y_q <= 4'd0;
                res_sad_q  <= 14'h3FFF;
            end
        end else if (res_valid_q && res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign cur_x_o     = cur_x_q;
    assign cur_y_o     = cur_y_q;
    // Each candidate column is held for two cycles: -8,-8,-7,-7,...,+7,+7.
    assign cand_col_o  = (state_q == StRun) ? (cnt_q[4:1] - 4'd8) : 4'd0;
    assign res_valid_o = res_valid_q;
    assign res_x_o     = res_x_q;
    assign res_y_o     = res_y_q;
    assign res_mv_x_o  = res_mv_x_q;
    assign res_mv_y_o  = res_mv_y_q;
    assign res_sad_o   = res_sad_q;
    assign err_sync_o  = err_q;

endmodule

// File: tb/tb_me_search_sched.sv
// Bench for me_search_sched on a 2x2 frame with FILL_CYC=2.
// A comparator model feeds each window, and a scoreboard checks every delivered result.
module tb_me_search_sched;

    localparam int unsigned Cols = 2;
    localparam int unsigned Rows = 2;
    localparam int unsigned Fill = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, sad_en_o, cmp_pause_o;
    logic [7:0]  cur_x_o, cur_y_o;
    logic [3:0]  cand_col_o;
    logic        cmp_finish_i = 1'b0;
    logic [3:0]  cmp_mv_x_i = 4'd0;
    logic [3:0]  cmp_mv_y_i = 4'd0;
    logic [13:0] cmp_sad_i = 14'd0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b1;
    logic [7:0]  res_x_o, res_y_o;
    logic [3:0]  res_mv_x_o, res_mv_y_o;
    logic [13:0] res_sad_o;
    logic        err_sync_o;

    me_search_sched #(.BLK_COLS(Cols), .BLK_ROWS(Rows), .FILL_CYC(Fill)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .sad_en_o(sad_en_o), .cmp_pause_o(cmp_pause_o), .cur_x_o(cur_x_o), .cur_y_o(cur_y_o),
        .cand_col_o(cand_col_o), .cmp_finish_i(cmp_finish_i), .cmp_mv_x_i(cmp_mv_x_i),
        .cmp_mv_y_i(cmp_mv_y_i), .cmp_sad_i(cmp_sad_i), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .res_x_o(res_x_o), .res_y_o(res_y_o),
        .res_mv_x_o(res_mv_x_o), .res_mv_y_o(res_mv_y_o), .res_sad_o(res_sad_o),
        .err_sync_o(err_sync_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard of {x, y, mv_x, mv_y, sad}
    logic [37:0] exp_q[$];

    // Controls owned by the main process
    logic finish_en  = 1'b1;
    logic spacing_on = 1'b0;

    // Comparator model and result monitor state
    int   idx = 0;
    int   blk_k = 0;
    int   last_rise = 0;
    logic have_rise = 1'b0;
    logic prev_valid = 1'b0;

    // Comparator model plus result monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [7:0]  ex, ey;
        logic [3:0]  emx, emy, ecc;
        logic [13:0] esad;
        if (!rst) begin
            idx = 0;
            blk_k = 0;
            cmp_finish_i = 1'b0;
            exp_q.delete();
            prev_valid = 1'b0;
            have_rise = 1'b0;
        end else begin
            if (!busy_o) begin
                blk_k = 0;
                have_rise = 1'b0;
            end
            if (res_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("res_unexpected", 64'd1, 64'd0);
                end else begin
                    check_eq("res", {res_x_o, res_y_o, res_mv_x_o, res_mv_y_o, res_sad_o},
                             exp_q[0]);
                    if (res_ready_i) void'(exp_q.pop_front());
                end
                if (!prev_valid) begin
                    if (spacing_on && have_rise) check_eq("spacing", 64'(cyc - last_rise), 64'd34);
                    last_rise = cyc;
                    have_rise = 1'b1;
                end
            end
            prev_valid = res_valid_o;
            if (!cmp_pause_o) begin
                ecc = 4'(idx / 2 - 8);
                check_eq("cand_col", cand_col_o, ecc);
                check_eq("run_slot_free", res_valid_o, 1'b0);
                if (idx == 31) begin
                    ex = 8'(blk_k % Cols);
                    ey = 8'(blk_k / Cols);
                    if (finish_en) begin
                        emx  = 4'(blk_k - 3);
                        emy  = 4'(5 - blk_k);
                        esad = 14'(100 + 7 * blk_k);
                        cmp_finish_i = 1'b1;
                        cmp_mv_x_i = emx;
                        cmp_mv_y_i = emy;
                        cmp_sad_i  = esad;
                        exp_q.push_back({ex, ey, emx, emy, esad});
                    end else begin
                        cmp_finish_i = 1'b0;
                        cmp_mv_x_i = 4'h6;
                        cmp_mv_y_i = 4'h2;
                        cmp_sad_i  = 14'd55;
                        exp_q.push_back({ex, ey, 4'd0, 4'd0, 14'h3FFF});
                    end
                    blk_k++;
                    idx = 0;
                end else begin
                    cmp_finish_i = 1'b0;
                    idx++;
                end
            end else begin
                // Stray strobe with junk data while paused; must be ignored.
                idx = 0;
                cmp_finish_i = 1'b1;
                cmp_mv_x_i = 4'hF;
                cmp_mv_y_i = 4'hF;
                cmp_sad_i  = 14'h1234;
            end
        end
    end

    task automatic check_reset(input string tag);
        check_eq({tag, "_ctrl"}, {busy_o, done_o, sad_en_o, cmp_pause_o, res_valid_o, err_sync_o},
                 6'b000100);
        check_eq({tag, "_pos"}, {cur_x_o, cur_y_o, cand_col_o}, 20'd0);
        check_eq({tag, "_res"}, {res_x_o, res_y_o, res_mv_x_o, res_mv_y_o, res_sad_o}, 38'd0);
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) check_eq("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        int dc;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;

        // Frame A: ready tied high, latency, ordering, spacing, done timing
        res_ready_i = 1'b1;
        spacing_on  = 1'b1;
        start_frame();
        check_eq("fill_ctrl", {busy_o, sad_en_o, cmp_pause_o}, 3'b111);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            n++;
            if (res_valid_o) break;
        end
        check_eq("first_latency", 64'(n + 1), 64'd36);
        wait_done(dc);
        check_eq("done_after_last", 64'(dc - last_rise), 64'd1);
        check_eq("busy_at_done", busy_o, 1'b0);
        check_eq("queue_a", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        check_eq("done_one_cycle", done_o, 1'b0);

        // Frame B: consumer stalls after first result
        spacing_on  = 1'b0;
        res_ready_i = 1'b0;
        start_frame();
        for (int i = 0; i < 200; i++) begin
            if (res_valid_o) break;
            @(posedge clk); #1;
        end
        check_eq("stall_first_valid", res_valid_o, 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check_eq("stall_fill", {sad_en_o, cmp_pause_o, res_valid_o}, 3'b111);
        end
        check_eq("stall_block", {cur_x_o, cur_y_o}, {8'd1, 8'd0});
        res_ready_i = 1'b1;
        wait_done(dc);
        check_eq("queue_b", 64'(exp_q.size()), 64'd0);
        check_eq("err_b", err_sync_o, 1'b0);

        // Frame C: comparator never finishes, start pulsed mid-frame
        finish_en = 1'b0;
        start_frame();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (blk_k == 1) break;
        end
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check_eq("mid_start_busy", busy_o, 1'b1);
        wait_done(dc);
        check_eq("err_sticky", err_sync_o, 1'b1);
        check_eq("queue_c", 64'(exp_q.size()), 64'd0);

        // Frame D: err cleared by start, reset during RUN of the third block
        finish_en = 1'b1;
        @(posedge clk); #1;
        check_eq("err_held", err_sync_o, 1'b1);
        start_frame();
        check_eq("err_cleared", err_sync_o, 1'b0);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (blk_k == 2 && !cmp_pause_o && idx > 4) begin
                n = 1;
                break;
            end
        end
        check_eq("reached_block3", 64'(n), 64'd1);
        rst = 1'b0;
        #1;
        check_reset("midrst");
        @(posedge clk); #1;
        check_reset("midrst_hold");
        rst = 1'b1;

        // Frame E: restart from (0,0) after reset
        start_frame();
        check_eq("restart_pos", {cur_x_o, cur_y_o}, 16'd0);
        wait_done(dc);
        check_eq("queue_e", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
